// File: rtl/branch_target_buffer_if.sv
// Fetch/execute port bundle for branch_target_buffer.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

// Lookup and update are single-cycle valid-qualified requests with no backpressure;
// o_ready is a status flag (table swept), not a ready handshake.
interface branch_target_buffer_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH
);
  logic                  i_lookup_valid;
  logic [ADDR_WIDTH-1:0] i_lookup_pc;
  logic                  o_hit;
  logic [ADDR_WIDTH-1:0] o_target;
  logic                  o_ready;
  logic                  i_update_valid;
  logic [ADDR_WIDTH-1:0] i_update_pc;
  logic [ADDR_WIDTH-1:0] i_update_target;
  logic                  i_update_taken;
  logic                  dbg_state;

  modport master (
    output i_lookup_valid, i_lookup_pc, i_update_valid, i_update_pc,
           i_update_target, i_update_taken,
    input  o_hit, o_target, o_ready, dbg_state
  );

  modport slave (
    input  i_lookup_valid, i_lookup_pc, i_update_valid, i_update_pc,
           i_update_target, i_update_taken,
    output o_hit, o_target, o_ready, dbg_state
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters and a post-reset clear sweep.
// Define BTB_BYPASS_EN to forward a same-cycle update into the lookup path.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_target_buffer #(
  parameter int ENTRIES    = 64,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_target_buffer_if.slave  bus
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;
  localparam logic [IDX-1:0] LAST_IDX = IDX'(ENTRIES - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IDX-1:0] sweep_q, sweep_d;
  logic           clr_en;
  logic           ready;

  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Sweep end is detected on the last index so non-power-of-two wrap never matters.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    clr_en  = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_en = 1'b1;
        if (sweep_q == LAST_IDX) begin
          state_d = ST_READY;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      ST_READY: ;
      default: state_d = ST_INIT;
    endcase
  end

  assign ready         = (state_q == ST_READY);
  assign bus.o_ready   = ready;
  assign bus.dbg_state = state_q;

  logic [IDX-1:0]        u_idx, l_idx;
  logic [TAG_W-1:0]      u_tag, l_tag;
  logic                  upd_en, u_hit;
  logic                  nx_we, nx_valid;
  logic [TAG_W-1:0]      nx_tag;
  logic [ADDR_WIDTH-1:0] nx_target;
  logic [1:0]            nx_ctr;

  assign u_idx  = bus.i_update_pc[IDX+1:2];
  assign u_tag  = bus.i_update_pc[ADDR_WIDTH-1:IDX+2];
  assign l_idx  = bus.i_lookup_pc[IDX+1:2];
  assign l_tag  = bus.i_lookup_pc[ADDR_WIDTH-1:IDX+2];
  assign upd_en = ready & ~rst & bus.i_update_valid;
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.i_lookup_pc[1:0], bus.i_update_pc[1:0]};

  // Post-update image of the addressed entry; feeds both the write and the bypass.
  always_comb begin
    nx_we     = 1'b0;
    nx_valid  = valid_q[u_idx];
    nx_tag    = tag_q[u_idx];
    nx_target = target_q[u_idx];
    nx_ctr    = ctr_q[u_idx];
    if (upd_en) begin
      if (bus.i_update_taken) begin
        nx_we     = 1'b1;
        nx_target = bus.i_update_target;
        if (u_hit) begin
          if (ctr_q[u_idx] != 2'b11) nx_ctr = ctr_q[u_idx] + 2'b01;
        end else begin
          nx_valid = 1'b1;
          nx_tag   = u_tag;
          nx_ctr   = 2'b10;
        end
      end else if (u_hit) begin
        nx_we = 1'b1;
        if (ctr_q[u_idx] == 2'b00) nx_valid = 1'b0;
        else                       nx_ctr   = ctr_q[u_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_q[sweep_q] <= 1'b0;
    end else if (nx_we) begin
      valid_q[u_idx]  <= nx_valid;
      tag_q[u_idx]    <= nx_tag;
      target_q[u_idx] <= nx_target;
      ctr_q[u_idx]    <= nx_ctr;
    end
  end

  logic                  lk_valid;
  logic [TAG_W-1:0]      lk_tag;
  logic [ADDR_WIDTH-1:0] lk_target;
  logic [1:0]            lk_ctr;
  logic                  hit;

  always_comb begin
    lk_valid  = valid_q[l_idx];
    lk_tag    = tag_q[l_idx];
    lk_target = target_q[l_idx];
    lk_ctr    = ctr_q[l_idx];
`ifdef BTB_BYPASS_EN
    if (nx_we && (u_idx == l_idx)) begin
      lk_valid  = nx_valid;
      lk_tag    = nx_tag;
      lk_target = nx_target;
      lk_ctr    = nx_ctr;
    end
`else
`endif
  end

  assign hit          = ready & bus.i_lookup_valid & lk_valid & (lk_tag == l_tag) & lk_ctr[1];
  assign bus.o_hit    = hit;
  assign bus.o_target = hit ? lk_target : '0;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed, table-driven bench for branch_target_buffer (64 entries, 32-bit PC).
module tb_branch_target_buffer;
`ifdef BTB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_target_buffer_if #(.ADDR_WIDTH(32)) bus ();

  branch_target_buffer #(.ENTRIES(64), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        ut;
    logic        lv;
    logic [31:0] lpc;
    logic        eh;
    logic [31:0] et;
  } vec_t;

  vec_t        tbl[$];
  logic [32:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic vec_t mk(logic uv, logic [31:0] upc, logic [31:0] utgt, logic ut,
                              logic lv, logic [31:0] lpc, logic eh, logic [31:0] et);
    vec_t v;
    v.uv = uv; v.upc = upc; v.utgt = utgt; v.ut = ut;
    v.lv = lv; v.lpc = lpc; v.eh = eh; v.et = et;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_update_valid  = v.uv;
    bus.i_update_pc     = v.upc;
    bus.i_update_target = v.utgt;
    bus.i_update_taken  = v.ut;
    bus.i_lookup_valid  = v.lv;
    bus.i_lookup_pc     = v.lpc;
  endtask

  // One cycle: drive after the edge, compare mid-cycle, commit at the next edge.
  task automatic apply(input vec_t v, input string nm);
    logic [32:0] e;
    @(posedge clk); #1;
    drive(v);
    exp_q.push_back({v.eh, v.et});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({nm, ".hit"}, {31'd0, bus.o_hit}, {31'd0, e[32]});
    chk({nm, ".target"}, bus.o_target, e[31:0]);
  endtask

  // Entered #1 after the edge where rst was released; cycle 0 is the current one.
  task automatic init_check(input int upd_cycle);
    for (int c = 0; c <= 64; c++) begin
      bus.i_lookup_valid  = 1'b1;
      bus.i_lookup_pc     = 32'h100;
      bus.i_update_valid  = (c == upd_cycle);
      bus.i_update_pc     = 32'h604;
      bus.i_update_target = 32'h900;
      bus.i_update_taken  = 1'b1;
      @(negedge clk);
      chk($sformatf("init.ready[%0d]", c), {31'd0, bus.o_ready}, {31'd0, (c == 64)});
      chk($sformatf("init.hit[%0d]", c), {31'd0, bus.o_hit}, 32'd0);
      if (c < 64) begin
        @(posedge clk); #1;
      end
    end
    bus.i_update_valid = 1'b0;
  endtask

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    drive(mk(0, 0, 0, 0, 1, 32'h100, 0, 0));
    @(posedge clk);
    @(negedge clk);
    chk("reset.ready", {31'd0, bus.o_ready}, 32'd0);
    chk("reset.hit", {31'd0, bus.o_hit}, 32'd0);
    chk("reset.target", bus.o_target, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    init_check(-1);

    tbl.push_back(mk(1, 32'h300, 32'h340, 1, 1, 32'h300, BYP, BYP ? 32'h340 : 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h300, 1, 32'h340));
    tbl.push_back(mk(1, 32'h100, 32'h200, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h300, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 1, 32'h200));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h200, 0, 0));
    tbl.push_back(mk(1, 32'h200, 32'h480, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h200, 1, 32'h480));
    tbl.push_back(mk(1, 32'h100, 32'h200, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 1, 32'h200));
    tbl.push_back(mk(1, 32'h100, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 0, 0));
    tbl.push_back(mk(1, 32'h100, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 0, 0));
    tbl.push_back(mk(1, 32'h100, 32'h204, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 0, 0));
    tbl.push_back(mk(1, 32'h100, 32'h208, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 1, 32'h208));
    tbl.push_back(mk(1, 32'h100, 32'h208, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h100, 32'h208, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h100, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 1, 32'h208));
    tbl.push_back(mk(1, 32'h100, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h100, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h100, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h100, 32'h20C, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 1, 32'h20C));
    tbl.push_back(mk(1, 32'h500, 32'h0, 0, 1, 32'h100, 1, 32'h20C));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h500, 0, 0));
    tbl.push_back(mk(1, 32'h104, 32'h700, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h105, 1, 32'h700));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h104, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 1, 32'h20C));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset from READY, then a second reset in the middle of the sweep.
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 1, 32'h100, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk($sformatf("sweep1.ready[%0d]", c), {31'd0, bus.o_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    init_check(40);

    apply(mk(0, 0, 0, 0, 1, 32'h100, 0, 0), "post.0x100");
    apply(mk(0, 0, 0, 0, 1, 32'h104, 0, 0), "post.0x104");
    apply(mk(0, 0, 0, 0, 1, 32'h604, 0, 0), "post.0x604");
    apply(mk(1, 32'h100, 32'hABC, 1, 0, 0, 0, 0), "post.upd");
    apply(mk(0, 0, 0, 0, 1, 32'h100, 1, 32'hABC), "post.hit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
